// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequencer for a multiplexed-bus RTC chip (address then data).
// Build option: define RTC_BUS_BCD_CHECK_EN to reject writes of non-BCD data.
//
// Ports
//   clk, reset        : rising-edge clock, async active-high reset
//   req_rd, req_wr    : one-cycle requests, sampled only when idle
//   addr, wdata       : register address / write data, latched on accept
//   busy, done, err   : status; done and err are one-cycle pulses
//   rdata             : last read result, updated when a read completes
//   cs_n, ad_n        : chip select, address(0)/data(1) select
//   wr_n, rd_n        : write / read strobes
//   ad_out, ad_oe     : bus drive value and driver enable
//   ad_in             : bus read-back
`timescale 1ns/1ps
module rtc_bus_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int STB_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_rd,
  input  logic       req_wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STB, A_HOLD,
    D_SETUP, D_STB, D_HOLD, DONE
  } state_t;

  localparam logic [7:0] SET_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STB_LD = 8'(STB_CYC - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_wr;

  state_t     w_nxt;
  logic [7:0] w_ld;
  logic       w_bcd_bad;
  logic       w_accept;
  logic       w_reject;
  logic       w_a_ph;
  logic       w_d_ph;

`ifdef RTC_BUS_BCD_CHECK_EN
  assign w_bcd_bad = req_wr &
                     ((wdata[7:4] > 4'd9) |
                      (wdata[3:0] > 4'd9));
`else
  assign w_bcd_bad = 1'b0;
`endif

  assign w_accept = (req_rd ^ req_wr) & ~w_bcd_bad;
  assign w_reject = (req_rd & req_wr) |
                    ((req_rd ^ req_wr) & w_bcd_bad);

  // Address / data phase of the state being left this edge;
  // pins follow the state one cycle later.
  assign w_a_ph = (r_state == A_SETUP) ||
                  (r_state == A_STB) ||
                  (r_state == A_HOLD);
  assign w_d_ph = (r_state == D_SETUP) ||
                  (r_state == D_STB) ||
                  (r_state == D_HOLD);

  always_comb begin
    w_nxt = r_state;
    w_ld  = 8'd0;
    unique case (r_state)
      IDLE:    begin w_nxt = IDLE;    w_ld = 8'd0;   end
      A_SETUP: begin w_nxt = A_STB;   w_ld = STB_LD; end
      A_STB:   begin w_nxt = A_HOLD;  w_ld = SET_LD; end
      A_HOLD:  begin w_nxt = D_SETUP; w_ld = SET_LD; end
      D_SETUP: begin w_nxt = D_STB;   w_ld = STB_LD; end
      D_STB:   begin w_nxt = D_HOLD;  w_ld = SET_LD; end
      D_HOLD:  begin w_nxt = DONE;    w_ld = 8'd0;   end
      DONE:    begin w_nxt = IDLE;    w_ld = 8'd0;   end
      default: begin w_nxt = IDLE;    w_ld = 8'd0;   end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= 8'd0;
      r_wdata <= 8'd0;
      r_wr    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 8'd0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      ad_out  <= 8'd0;
      ad_oe   <= 1'b0;
    end else begin
      err <= 1'b0;

      if (r_state == IDLE) begin
        if (w_accept) begin
          r_state <= A_SETUP;
          r_cnt   <= SET_LD;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_wr    <= req_wr;
        end else if (w_reject) begin
          err <= 1'b1;
        end
      end else if (r_cnt == 8'd0) begin
        r_state <= w_nxt;
        r_cnt   <= w_ld;
      end else begin
        r_cnt <= r_cnt - 8'd1;
      end

      busy <= (r_state == IDLE) ? w_accept
                                : (r_state != DONE);
      done <= (r_state == DONE);

      cs_n  <= (r_state == IDLE) || (r_state == DONE);
      ad_n  <= ~w_a_ph;
      wr_n  <= ~((r_state == A_STB) ||
                 ((r_state == D_STB) && r_wr));
      rd_n  <= ~((r_state == D_STB) && !r_wr);
      ad_oe <= w_a_ph || (w_d_ph && r_wr);

      if (w_a_ph)
        ad_out <= r_addr;
      else if (w_d_ph && r_wr)
        ad_out <= r_wdata;
      else
        ad_out <= 8'd0;

      // First D_HOLD state cycle is the edge on which rd_n rises:
      // the last edge of the read strobe.
      if ((r_state == D_HOLD) && (r_cnt == SET_LD) && !r_wr)
        rdata <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: randomized scoreboard bench for rtc_bus_ctrl.
// Driver queues expected transactions; a bus monitor rebuilds and checks them.
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;

  localparam int S = 2;
  localparam int T = 4;
  localparam int LAT = 4 * S + 2 * T + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_rd = 1'b0;
  logic       req_wr = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] ad_in;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic       cs_n, ad_n, wr_n, rd_n;
  logic [7:0] ad_out;
  logic       ad_oe;

  logic [7:0] rd_val = 8'h00;
  longint     cyc = 0;
  int         tests = 0;
  int         fails = 0;

  // RTC model: presents rd_val only while it is being strobed.
  assign ad_in = rd_n ? ~rd_val : rd_val;

  rtc_bus_ctrl #(.SETUP_CYC(S), .STB_CYC(T)) dut (
    .clk(clk), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr),
    .addr(addr), .wdata(wdata), .ad_in(ad_in),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
    .ad_out(ad_out), .ad_oe(ad_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 rejected
    logic [7:0] a;
    logic [7:0] d;
    longint     acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic bit bcd_bad(input logic [7:0] w);
`ifdef RTC_BUS_BCD_CHECK_EN
    return (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- monitor ----------------
  int         a_cnt, d_cnt, rd_cnt, wr_pulses;
  logic [7:0] a_val, d_val, exp_rdata;
  logic       prev_wr_n;
  exp_t       m;

  task automatic clear_obs();
    a_cnt = 0; d_cnt = 0; rd_cnt = 0; wr_pulses = 0;
    a_val = 8'h00; d_val = 8'h00;
  endtask

  initial begin
    clear_obs();
    prev_wr_n = 1'b1;
    exp_rdata = 8'h00;
  end

  always @(negedge clk) begin
    if (reset) begin
      clear_obs();
      prev_wr_n = 1'b1;
      exp_rdata = 8'h00;
    end else begin
      check("strobe_excl", longint'(!wr_n && !rd_n), 0);
      check("oe_during_rd", longint'(ad_oe && !rd_n), 0);
      if (!wr_n && prev_wr_n) wr_pulses++;
      if (!wr_n && !ad_n) begin a_cnt++; a_val = ad_out; end
      if (!wr_n && ad_n)  begin d_cnt++; d_val = ad_out; end
      if (!rd_n) rd_cnt++;
      prev_wr_n = wr_n;

      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          m = sb.pop_front();
          check("done_kind", d_cnt > 0 ? 0 : 1, m.kind);
          check("addr", a_val, m.a);
          check("addr_stb_len", a_cnt, T);
          check("latency", cyc - m.acc, LAT);
          check("busy_at_done", busy, 0);
          check("cs_n_at_done", cs_n, 1);
          check("oe_at_done", ad_oe, 0);
          if (m.kind == 0) begin
            check("wdata", d_val, m.d);
            check("data_stb_len", d_cnt, T);
            check("wr_pulses", wr_pulses, 2);
            check("rd_cnt_on_wr", rd_cnt, 0);
            check("rdata_hold", rdata, exp_rdata);
          end else begin
            exp_rdata = m.d;
            check("rdata", rdata, m.d);
            check("rd_stb_len", rd_cnt, T);
            check("wr_pulses", wr_pulses, 1);
          end
        end
        clear_obs();
      end

      if (err) begin
        if (sb.size() == 0) begin
          check("unexpected_err", 1, 0);
        end else begin
          m = sb.pop_front();
          check("err_kind", 2, m.kind);
          check("err_latency", cyc - m.acc, 0);
          check("busy_at_err", busy, 0);
          check("cs_n_at_err", cs_n, 1);
          check("no_bus_on_err", a_cnt + rd_cnt + wr_pulses, 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // kind: 0 write, 1 read, 2 both requests at once.
  task automatic run_txn(input int kind,
                         input logic [7:0] a,
                         input logic [7:0] w,
                         input logic [7:0] rv,
                         input bit spam);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("idle_timeout", 1, 0);
    addr   = a;
    wdata  = w;
    rd_val = rv;
    req_wr = (kind != 1);
    req_rd = (kind != 0);
    e.a    = a;
    e.d    = (kind == 1) ? rv : w;
    e.acc  = cyc + 1;
    e.kind = (kind == 2 || (kind == 0 && bcd_bad(w))) ? 2 : kind;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_wr = 1'b0;
    req_rd = 1'b0;
    if (spam && e.kind != 2) begin
      repeat (40) begin
        @(negedge clk);
        if (!busy) break;
        req_wr = ($urandom_range(0, 2) == 0);
        req_rd = ($urandom_range(0, 3) == 0);
      end
      req_wr = 1'b0;
      req_rd = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk); n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic reset_mid_write();
    int n;
    drain();
    @(negedge clk);
    addr = 8'h40; wdata = 8'h12; req_wr = 1'b1;
    @(posedge clk);
    #1 req_wr = 1'b0;
    n = 0;
    while (wr_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("reach_a_stb", longint'(n < 50), 1);
    #3 reset = 1'b1;
    #1;
    check("rst_wr_n", wr_n, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_cs_n0", cs_n, 1);
    check("rst_ad_n0", ad_n, 1);
    check("rst_wr_n0", wr_n, 1);
    check("rst_rd_n0", rd_n, 1);
    check("rst_ad_oe0", ad_oe, 0);
    check("rst_ad_out0", ad_out, 0);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_err0", err, 0);
    check("rst_rdata0", rdata, 0);
    @(negedge clk);
    reset = 1'b0;

    run_txn(0, 8'h22, 8'h45, 8'h00, 1'b0);
    run_txn(1, 8'h21, 8'h00, 8'h37, 1'b0);
    run_txn(2, 8'h10, 8'h11, 8'h00, 1'b0);
    run_txn(0, 8'h30, 8'h11, 8'h00, 1'b1);
    run_txn(1, 8'h31, 8'h00, 8'hC3, 1'b1);
    run_txn(0, 8'h32, 8'h5A, 8'h00, 1'b0);
    run_txn(0, 8'h33, 8'h59, 8'h00, 1'b0);
    reset_mid_write();
    run_txn(0, 8'h44, 8'h27, 8'h00, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 9);
      run_txn(k == 0 ? 2 : (k < 5 ? 0 : 1),
              8'($urandom), 8'($urandom), 8'($urandom),
              bit'($urandom_range(0, 1)));
    end

    drain();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
